// File: rtl/weight_fetch_sequencer_if.sv
// Weight fetch sequencer bundle: loader, BRAM port and MAC stream.
// The sequencer side uses the slave modport.
interface weight_fetch_sequencer_if #(
  parameter int AW = 5,
  parameter int DW = 16
);
  logic          START;
  logic          STALL;
  logic          LD_REQ;
  logic [AW-1:0] LD_ADDR;
  logic [DW-1:0] LD_DATA;
  logic          LD_ACK;
  logic [AW-1:0] BRAM_ADDR;
  logic [DW-1:0] BRAM_DI;
  logic          BRAM_EN;
  logic          BRAM_WE;
  logic [DW-1:0] BRAM_DO;
  logic [DW-1:0] W_OUT;
  logic [AW-1:0] W_IDX;
  logic          W_VALID;
  logic          W_LAST;
  logic          BUSY;
  logic          DONE;

  modport slave (
    input  START, STALL, LD_REQ,
    input  LD_ADDR, LD_DATA, BRAM_DO,
    output LD_ACK, BRAM_ADDR, BRAM_DI,
    output BRAM_EN, BRAM_WE,
    output W_OUT, W_IDX, W_VALID,
    output W_LAST, BUSY, DONE
  );

  modport master (
    output START, STALL, LD_REQ,
    output LD_ADDR, LD_DATA, BRAM_DO,
    input  LD_ACK, BRAM_ADDR, BRAM_DI,
    input  BRAM_EN, BRAM_WE,
    input  W_OUT, W_IDX, W_VALID,
    input  W_LAST, BUSY, DONE
  );
endinterface

// File: rtl/weight_fetch_sequencer.sv
// Shares one single-port weight BRAM between a host loader
// and an in-order weight stream feeding the neuron MAC.
module weight_fetch_sequencer #(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int DW    = 16
) (
  input logic CLK,
  input logic RST_N,
  weight_fetch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, LOAD, FETCH, DRAIN
  } state_e;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          ack_q, ack_d;
  logic          en_q, en_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] di_q, di_d;
  logic [DW-1:0] w_out_q, w_out_d;
  logic [AW-1:0] w_idx_q, w_idx_d;
  logic          w_valid_q, w_valid_d;
  logic          w_last_q, w_last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    ack_d     = 1'b0;
    en_d      = 1'b0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    di_d      = di_q;
    done_d    = 1'b0;
    w_out_d   = w_out_q;
    w_idx_d   = w_idx_q;
    // A read issued this cycle lands at the next posedge.
    rd        = en_q & ~we_q;
    w_valid_d = rd;
    w_last_d  = rd & (addr_q == LAST);
    if (rd) begin
      w_out_d = bus.BRAM_DO;
      w_idx_d = addr_q;
    end
    unique case (state_q)
      IDLE: begin
        if (bus.LD_REQ) begin
          state_d = LOAD;
          ack_d   = 1'b1;
          pend_d  = pend_q | bus.START;
          if ({1'b0, bus.LD_ADDR} < DEPTH_W) begin
            en_d   = 1'b1;
            we_d   = 1'b1;
            addr_d = bus.LD_ADDR;
            di_d   = bus.LD_DATA;
          end
        end else if (bus.START | pend_q) begin
          state_d = FETCH;
          pend_d  = 1'b0;
          cnt_d   = '0;
          en_d    = 1'b1;
          addr_d  = '0;
        end
      end
      LOAD: begin
        state_d = IDLE;
        pend_d  = pend_q | bus.START;
      end
      FETCH: begin
        pend_d = pend_q | bus.START;
        if (cnt_q == LAST) begin
          state_d = DRAIN;
        end else if (!bus.STALL) begin
          cnt_d  = cnt_q + 1'b1;
          en_d   = 1'b1;
          addr_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        pend_d  = pend_q | bus.START;
        state_d = IDLE;
        done_d  = 1'b1;
      end
    endcase
    // BUSY stays up through the DONE cycle.
    busy_d = (state_d != IDLE) | done_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      ack_q     <= 1'b0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      di_q      <= '0;
      w_out_q   <= '0;
      w_idx_q   <= '0;
      w_valid_q <= 1'b0;
      w_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      ack_q     <= ack_d;
      en_q      <= en_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      di_q      <= di_d;
      w_out_q   <= w_out_d;
      w_idx_q   <= w_idx_d;
      w_valid_q <= w_valid_d;
      w_last_q  <= w_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.LD_ACK    = ack_q;
  assign bus.BRAM_EN   = en_q;
  assign bus.BRAM_WE   = we_q;
  assign bus.BRAM_ADDR = addr_q;
  assign bus.BRAM_DI   = di_q;
  assign bus.W_OUT     = w_out_q;
  assign bus.W_IDX     = w_idx_q;
  assign bus.W_VALID   = w_valid_q;
  assign bus.W_LAST    = w_last_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Directed bench: BRAM model, expected-weight queue,
// and a negedge monitor that pops and checks every W_VALID.
module tb_weight_fetch_sequencer;

  localparam int DEPTH = 28;
  localparam int AW    = 5;
  localparam int DW    = 16;

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  weight_fetch_sequencer_if #(.AW(AW), .DW(DW)) bus ();

  weight_fetch_sequencer #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] mem [32];
  logic [DW-1:0] model [32];
  exp_t q [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int vcount, first_v, last_v;
  int busy_cnt, done_cnt, done_cyc, ack_cyc;
  int vcyc [32];
  int s;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (bus.BRAM_EN) begin
      if (bus.BRAM_WE) mem[bus.BRAM_ADDR] <= bus.BRAM_DI;
      else bus.BRAM_DO <= mem[bus.BRAM_ADDR];
    end
  end

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return 64'({bus.LD_ACK, bus.BRAM_ADDR, bus.BRAM_DI,
                bus.BRAM_EN, bus.BRAM_WE, bus.W_OUT,
                bus.W_IDX, bus.W_VALID, bus.W_LAST,
                bus.BUSY, bus.DONE});
  endfunction

  always @(negedge CLK) begin
    if (RST_N) begin
      if (bus.BUSY) busy_cnt++;
      if (bus.DONE) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.LD_ACK) ack_cyc = cyc;
      if (bus.W_VALID) begin
        exp_t e;
        vcount++;
        last_v = cyc;
        if (first_v < 0) first_v = cyc;
        vcyc[bus.W_IDX] = cyc;
        if (q.size() == 0) begin
          chk("unexpected_valid", 64'(bus.W_IDX), 64'hFFFF);
        end else begin
          e = q.pop_front();
          chk("w_idx", 64'(bus.W_IDX), 64'(e.idx));
          chk("w_out", 64'(bus.W_OUT), 64'(e.data));
          chk("w_last", 64'(bus.W_LAST), 64'(e.last));
        end
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic clr();
    vcount   = 0;
    first_v  = -1;
    last_v   = -1;
    busy_cnt = 0;
    done_cnt = 0;
    done_cyc = -1;
    ack_cyc  = -1;
  endtask

  task automatic push_stream();
    for (int i = 0; i < DEPTH; i++) begin
      exp_t e;
      e.idx  = AW'(i);
      e.data = model[i];
      e.last = (i == DEPTH - 1);
      q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
  endtask

  task automatic wait_done(int target, int max);
    for (int i = 0; i < max && done_cnt < target; i++)
      tick();
    chk("done_seen", 64'(done_cnt), 64'(target));
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 10 && !bus.LD_ACK; i++) tick();
    chk("ld_ack_seen", 64'(bus.LD_ACK), 64'd1);
  endtask

  initial begin
    bus.START = 0;
    bus.STALL = 0;
    bus.LD_REQ = 0;
    bus.LD_ADDR = '0;
    bus.LD_DATA = '0;
    bus.BRAM_DO = '0;
    for (int i = 0; i < 32; i++) begin
      mem[i] = DW'(i * 3);
      model[i] = DW'(i * 3);
      vcyc[i] = -1;
    end
    clr();

    repeat (3) tick();
    chk("reset_outs", all_out(), 64'd0);
    chk("reset_busy", 64'(bus.BUSY), 64'd0);
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_en", 64'(bus.BRAM_EN), 64'd0);
    end

    clr();
    push_stream();
    s = cyc;
    pulse_start();
    wait_done(1, 80);
    chk("full_first_v", 64'(first_v), 64'(s + 2));
    chk("full_last_v", 64'(last_v), 64'(s + 29));
    chk("full_count", 64'(vcount), 64'(DEPTH));
    chk("full_done_cyc", 64'(done_cyc), 64'(s + 30));
    chk("full_busy", 64'(busy_cnt), 64'd30);
    chk("full_q_empty", 64'(q.size()), 64'd0);
    repeat (3) tick();

    clr();
    push_stream();
    s = cyc;
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      if (bus.BRAM_EN && !bus.BRAM_WE &&
          bus.BRAM_ADDR == 5) break;
      tick();
    end
    chk("stall_trig", 64'(bus.BRAM_ADDR), 64'd5);
    bus.STALL = 1'b1;
    repeat (4) tick();
    bus.STALL = 1'b0;
    wait_done(1, 80);
    chk("stall_done_cyc", 64'(done_cyc), 64'(s + 34));
    chk("stall_gap", 64'(vcyc[6] - vcyc[5]), 64'd5);
    chk("stall_count", 64'(vcount), 64'(DEPTH));
    repeat (3) tick();

    bus.LD_REQ = 1'b1;
    bus.LD_ADDR = 5'd7;
    bus.LD_DATA = 16'hA5A5;
    wait_ack();
    chk("ld_we", 64'(bus.BRAM_WE), 64'd1);
    chk("ld_en", 64'(bus.BRAM_EN), 64'd1);
    chk("ld_addr", 64'(bus.BRAM_ADDR), 64'd7);
    chk("ld_di", 64'(bus.BRAM_DI), 64'hA5A5);
    bus.LD_REQ = 1'b0;
    model[7] = 16'hA5A5;
    tick();
    chk("ld_ack_pulse", 64'(bus.LD_ACK), 64'd0);
    chk("ld_en_off", 64'(bus.BRAM_EN), 64'd0);
    clr();
    push_stream();
    pulse_start();
    wait_done(1, 80);
    chk("ld_rd_count", 64'(vcount), 64'(DEPTH));
    repeat (2) tick();

    bus.LD_REQ = 1'b1;
    bus.LD_ADDR = 5'd30;
    bus.LD_DATA = 16'hFFFF;
    wait_ack();
    chk("oob_en", 64'(bus.BRAM_EN), 64'd0);
    chk("oob_we", 64'(bus.BRAM_WE), 64'd0);
    bus.LD_REQ = 1'b0;
    repeat (2) tick();

    clr();
    bus.LD_ADDR = 5'd3;
    bus.LD_DATA = 16'h1234;
    model[3] = 16'h1234;
    push_stream();
    s = cyc;
    bus.LD_REQ = 1'b1;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    chk("cont_ack", 64'(bus.LD_ACK), 64'd1);
    chk("cont_we", 64'(bus.BRAM_WE), 64'd1);
    bus.LD_REQ = 1'b0;
    wait_done(1, 80);
    chk("cont_first_v", 64'(first_v), 64'(s + 4));
    chk("cont_count", 64'(vcount), 64'(DEPTH));
    repeat (2) tick();

    clr();
    push_stream();
    pulse_start();
    repeat (8) tick();
    bus.LD_REQ = 1'b1;
    bus.LD_ADDR = 5'd9;
    bus.LD_DATA = 16'h0BEE;
    wait_done(1, 80);
    chk("mid_ld_no_ack", 64'(ack_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("mid_ld_ack", 64'(bus.LD_ACK), 64'd1);
    chk("mid_ld_ack_cyc", 64'(cyc), 64'(done_cyc + 1));
    bus.LD_REQ = 1'b0;
    model[9] = 16'h0BEE;
    repeat (2) tick();

    clr();
    push_stream();
    push_stream();
    pulse_start();
    repeat (10) tick();
    pulse_start();
    repeat (4) tick();
    pulse_start();
    wait_done(2, 120);
    chk("dbl_count", 64'(vcount), 64'(2 * DEPTH));
    chk("dbl_q_empty", 64'(q.size()), 64'd0);
    repeat (40) tick();
    chk("dbl_no_third", 64'(done_cnt), 64'd2);
    chk("dbl_idle", 64'(bus.BUSY), 64'd0);

    clr();
    push_stream();
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      if (bus.W_VALID && bus.W_IDX == 13) break;
      tick();
    end
    chk("rst_trig", 64'(bus.W_IDX), 64'd13);
    #1;
    RST_N = 1'b0;
    #1;
    chk("async_rst_outs", all_out(), 64'd0);
    q.delete();
    clr();
    repeat (2) tick();
    RST_N = 1'b1;
    repeat (5) tick();
    chk("rst_no_done", 64'(done_cnt), 64'd0);
    chk("rst_no_valid", 64'(vcount), 64'd0);
    chk("rst_no_pend", 64'(bus.BUSY), 64'd0);
    clr();
    push_stream();
    s = cyc;
    pulse_start();
    wait_done(1, 80);
    chk("post_rst_first", 64'(first_v), 64'(s + 2));
    chk("post_rst_count", 64'(vcount), 64'(DEPTH));
    chk("post_rst_q", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
